risc_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage replacing the fixed 13-bit/5-bit fetch unit between instruction memory and decode. Drives a fetch address to instruction memory, receives instructions with fixed one-cycle latency, buffers them in a small prefetch queue, and presents one instruction per cycle to decode. Adds decode back-pressure (stall) and branch/jump redirect with pipeline flush, neither of which the previous generation supports.

---
 rtl/risc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_risc_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: instruction fetch stage with prefetch queue,
// decode back-pressure and branch redirect flush.
module risc_fetch_unit #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP = '0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inf_addr;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic [INSTR_W-1:0] r_q_instr [QDEPTH];
  logic [ADDR_W-1:0]  r_q_addr  [QDEPTH];
  logic [INSTR_W-1:0] r_ir;
  logic [ADDR_W-1:0]  r_ir_pc;
  logic               r_ir_valid;

  logic [CW-1:0] w_occ;
  logic          w_req;
  logic          w_run;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_bypass;

  // Request throttling and queue push/pop/bypass decisions
  always_comb begin
    w_occ    = r_count + CW'(r_inflight);
    w_req    = !rst && !redirect && (w_occ < CW'(QDEPTH));
    w_run    = !stall && !redirect;
    w_empty  = (r_count == '0);
    w_pop    = w_run && !w_empty;
    w_bypass = w_run && w_empty && r_inflight;
    w_push   = r_inflight && !redirect && !w_bypass;
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;

  // PC, in-flight tracking and queue pointers; redirect flushes all
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_inf_addr <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc       <= r_pc + ADDR_W'(1);
        r_inf_addr <= r_pc;
      end
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push) r_tail <= r_tail + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents only meaningful below r_count
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_instr[r_tail] <= imem_data;
      r_q_addr[r_tail]  <= r_inf_addr;
    end
  end

  // Decode register: queue head first, then bypass, else bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir       <= NOP;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (redirect) begin
      r_ir       <= NOP;
      r_ir_valid <= 1'b0;
    end else if (w_pop) begin
      r_ir       <= r_q_instr[r_head];
      r_ir_pc    <= r_q_addr[r_head];
      r_ir_valid <= 1'b1;
    end else if (w_bypass) begin
      r_ir       <= imem_data;
      r_ir_pc    <= r_inf_addr;
      r_ir_valid <= 1'b1;
    end else if (!stall) begin
      r_ir       <= NOP;
      r_ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb_risc_fetch_unit: directed checks of fetch, stall, redirect,
// wrap and reset on default and wide/deep configurations.
module tb_risc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [4:0]  redirect_pc;

  logic        imem_req;
  logic [4:0]  imem_addr;
  logic [12:0] imem_data;
  logic [4:0]  pc;
  logic [12:0] ir;
  logic [4:0]  ir_pc;
  logic        ir_valid;

  logic        v_req;
  logic [4:0]  v_addr;
  logic [15:0] v_data;
  logic [4:0]  v_pc;
  logic [15:0] v_ir;
  logic [4:0]  v_ir_pc;
  logic        v_valid;

  logic [4:0]  ma;
  logic [4:0]  mb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  risc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid)
  );

  risc_fetch_unit #(.INSTR_W(16), .ADDR_W(5), .QDEPTH(4)) dut_v (
    .clk(clk), .rst(rst),
    .imem_req(v_req), .imem_addr(v_addr), .imem_data(v_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(v_pc), .ir(v_ir), .ir_pc(v_ir_pc), .ir_valid(v_valid)
  );

  always @(posedge clk) begin
    ma <= imem_addr;
    mb <= v_addr;
  end
  assign imem_data = 13'h100 + 13'(ma);
  assign v_data    = 16'h8000 + 16'(mb);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ir(input logic [4:0] p);
    chk("ir_valid", 32'(ir_valid), 32'd1);
    chk("ir_pc", 32'(ir_pc), 32'(p));
    chk("ir", 32'(ir), 32'(13'h100 + 13'(p)));
    chk("v_ir_valid", 32'(v_valid), 32'd1);
    chk("v_ir_pc", 32'(v_ir_pc), 32'(p));
    chk("v_ir", 32'(v_ir), 32'(16'h8000 + 16'(p)));
  endtask

  task automatic expect_bubble();
    chk("bub_valid", 32'(ir_valid), 32'd0);
    chk("bub_ir", 32'(ir), 32'd0);
    chk("v_bub_valid", 32'(v_valid), 32'd0);
    chk("v_bub_ir", 32'(v_ir), 32'd0);
  endtask

  task automatic expect_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("v_rst_pc", 32'(v_pc), 32'd0);
    chk("v_rst_ir", 32'(v_ir), 32'd0);
    chk("v_rst_ir_pc", 32'(v_ir_pc), 32'd0);
    chk("v_rst_valid", 32'(v_valid), 32'd0);
    chk("v_rst_req", 32'(v_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    expect_reset();

    // cycle n: first fetch at RESET_PC
    rst = 1'b0;
    #1;
    chk("n_req", 32'(imem_req), 32'd1);
    chk("n_addr", 32'(imem_addr), 32'd0);
    chk("v_n_req", 32'(v_req), 32'd1);
    tick();
    expect_bubble();
    tick();
    expect_ir(5'd0);

    // streaming across the PC wrap
    for (int i = 1; i <= 40; i++) begin
      tick();
      expect_ir(5'(i));
    end

    // five-cycle stall while showing address 8
    stall = 1'b1;
    #1;
    chk("stall_req0", 32'(imem_req), 32'd1);
    tick();
    chk("stall_req1", 32'(imem_req), 32'd0);
    expect_ir(5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", 32'(imem_req), 32'd0);
      expect_ir(5'd8);
    end
    tick();
    expect_ir(5'd8);
    stall = 1'b0;
    for (int i = 9; i <= 13; i++) begin
      tick();
      expect_ir(5'(i));
    end

    // redirect to 20 while streaming
    redirect = 1'b1;
    redirect_pc = 5'd20;
    #1;
    chk("redir_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    expect_bubble();
    chk("redir_addr", 32'(imem_addr), 32'd20);
    chk("redir_req1", 32'(imem_req), 32'd1);
    tick();
    expect_bubble();
    tick();
    expect_ir(5'd20);
    tick();
    expect_ir(5'd21);
    tick();
    expect_ir(5'd22);

    // fill the queue under stall, then redirect with stall high
    stall = 1'b1;
    tick();
    tick();
    tick();
    expect_ir(5'd22);
    chk("full_req", 32'(imem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 5'd3;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    expect_bubble();
    chk("rs_addr", 32'(imem_addr), 32'd3);
    chk("rs_req", 32'(imem_req), 32'd1);
    chk("v_rs_req", 32'(v_req), 32'd1);
    tick();
    expect_bubble();
    tick();
    expect_ir(5'd3);
    tick();
    expect_ir(5'd4);
    tick();
    expect_ir(5'd5);

    // one-cycle reset mid-stream
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    tick();
    expect_reset();
    rst = 1'b0;
    #1;
    chk("mrst_n_req", 32'(imem_req), 32'd1);
    chk("mrst_n_addr", 32'(imem_addr), 32'd0);
    tick();
    expect_bubble();
    tick();
    expect_ir(5'd0);
    tick();
    expect_ir(5'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
